// File: rtl/pop_ui_pkg.sv
// Shared front-panel timing constants and channel state type for the POP user interface.
package pop_ui_pkg;

    localparam int unsigned DEF_NUM_BUTTONS        = 6;
    localparam int unsigned DEF_TICK_DIV           = 250;
    localparam int unsigned DEF_DEBOUNCE_TICKS     = 50;
    localparam int unsigned DEF_REPEAT_DELAY_TICKS = 5000;
    localparam int unsigned DEF_REPEAT_RATE_TICKS  = 1000;

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} ch_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side signal bundle: raw pins and repeat enables in, conditioned levels and strobes out.
interface button_conditioner_if
    import pop_ui_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS = DEF_NUM_BUTTONS
);
    logic [NUM_BUTTONS-1:0] buttons_n;
    logic [NUM_BUTTONS-1:0] repeat_en;
    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] press_pulse;
    logic [NUM_BUTTONS-1:0] release_pulse;
    logic [NUM_BUTTONS-1:0] action_pulse;
    logic                   tick;

    modport slave (
        input  buttons_n, repeat_en,
        output level, press_pulse, release_pulse, action_pulse, tick
    );

    modport master (
        output buttons_n, repeat_en,
        input  level, press_pulse, release_pulse, action_pulse, tick
    );
endinterface

// File: rtl/button_channel.sv
// One button channel: tick-based debounce, IDLE/HELD/REPEAT hold tracking and registered strobes.
module button_channel
    import pop_ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS     = DEF_DEBOUNCE_TICKS,
    parameter int unsigned REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
    parameter int unsigned REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
) (
    input  logic clk_2M5,
    input  logic reset_n,
    input  logic tick_i,
    input  logic sync_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic action_o
);
    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned HW = $clog2(max_u(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS) + 1);
    localparam logic [HW-1:0] HOLD_MAX = '1;

    ch_state_e     state_q, state_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d, db_inc;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
    logic          level_q, level_d;
    logic          press_q, press_d, release_q, release_d, action_q, action_d;
    logic          rise, fall, rpt;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        rise     = 1'b0;
        fall     = 1'b0;
        db_inc   = db_cnt_q + DW'(1);
        if (tick_i) begin
            if (sync_i == level_q) begin
                db_cnt_d = '0;
            end else if (db_inc == DW'(DEBOUNCE_TICKS)) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
                rise     = ~level_q;
                fall     = level_q;
            end else begin
                db_cnt_d = db_inc;
            end
        end
    end

    // Release is tested before the repeat threshold so it wins on a shared tick.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rpt        = 1'b0;
        hold_inc   = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HW'(1);
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (tick_i) begin
                    hold_cnt_d = hold_inc;
                    if (repeat_en_i && (hold_inc >= HW'(REPEAT_DELAY_TICKS))) begin
                        rpt        = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = REPEAT;
                    end
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (tick_i) begin
                    hold_cnt_d = hold_inc;
                    if (repeat_en_i && (hold_inc >= HW'(REPEAT_RATE_TICKS))) begin
                        rpt        = 1'b1;
                        hold_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        press_d   = rise;
        release_d = fall;
        action_d  = rise | rpt;
    end

    always_ff @(posedge clk_2M5 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            action_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            action_q   <= action_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign action_o  = action_q;

endmodule

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: two-flop synchroniser, shared sample-tick prescaler and
// one debounce/auto-repeat channel per button.
module button_conditioner
    import pop_ui_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS        = DEF_NUM_BUTTONS,
    parameter int unsigned TICK_DIV           = DEF_TICK_DIV,
    parameter int unsigned DEBOUNCE_TICKS     = DEF_DEBOUNCE_TICKS,
    parameter int unsigned REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
    parameter int unsigned REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
) (
    input logic                 clk_2M5,
    input logic                 reset_n,
    button_conditioner_if.slave bus
);
    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [NUM_BUTTONS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic                   tick;
    logic [NUM_BUTTONS-1:0] level_w, press_w, release_w, action_w;

    // Pins are active-low; inverting before the first flop makes reset mean "released".
    always_comb begin
        sync1_d = ~bus.buttons_n;
        sync2_d = sync1_q;
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk_2M5 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
        end
    end

    for (genvar i = 0; i < int'(NUM_BUTTONS); i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_TICKS    (DEBOUNCE_TICKS),
            .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
            .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS)
        ) u_ch (
            .clk_2M5    (clk_2M5),
            .reset_n    (reset_n),
            .tick_i     (tick),
            .sync_i     (sync2_q[i]),
            .repeat_en_i(bus.repeat_en[i]),
            .level_o    (level_w[i]),
            .press_o    (press_w[i]),
            .release_o  (release_w[i]),
            .action_o   (action_w[i])
        );
    end

    assign bus.level         = level_w;
    assign bus.press_pulse   = press_w;
    assign bus.release_pulse = release_w;
    assign bus.action_pulse  = action_w;
    assign bus.tick          = tick;

endmodule
